// File: rtl/hw_thread_scheduler.sv
// Two-context thread scheduler: time-slices the pipeline between thread 0
// and an optional thread 1 by draining with NOPs and redirecting fetch.
module hw_thread_scheduler #(
  parameter int          QUANTUM      = 1024,
  parameter int          DRAIN_CYCLES = 5,
  parameter logic [31:0] RESET_PC     = 32'h1eceb000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        commit_valid,
  input  logic [31:0] commit_pc_wdata,
  input  logic        dstall,
  input  logic        yield_req,
  input  logic        thread1_start,
  input  logic [31:0] thread1_start_pc,
  output logic        hardware_scheduler_en,
  output logic        hardware_scheduler_swap_pc,
  output logic [31:0] hardware_scheduler_pc,
  output logic        active_thread
);

  localparam int QW = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [QW-1:0] QMAX = QW'(QUANTUM - 1);
  localparam logic [DW-1:0] DMAX = DW'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_SWAP
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [QW-1:0] r_qcnt;
  logic [DW-1:0] r_dcnt;
  logic          r_active;
  logic          r_valid1;
  logic [31:0]   r_saved0;
  logic [31:0]   r_saved1;
  logic [31:0]   r_last;

  logic          w_other_valid;
  logic          w_go;
  logic          w_dexp;
  logic [31:0]   w_other_pc;

  // thread 0 is always valid, so only thread 0 can lack a partner
  assign w_other_valid = r_active | r_valid1;
  assign w_go   = w_other_valid &&
                  (((r_qcnt == QMAX) && !dstall) || yield_req);
  assign w_dexp = (r_dcnt == DMAX) && !dstall;
  assign w_other_pc = r_active ? r_saved0 : r_saved1;

  always_comb begin
    w_next = r_state;
    hardware_scheduler_en      = 1'b0;
    hardware_scheduler_swap_pc = 1'b0;
    hardware_scheduler_pc      = 32'h0;
    unique case (r_state)
      S_RUN: begin
        if (w_go) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        hardware_scheduler_en = 1'b1;
        if (w_dexp) w_next = S_SWAP;
      end
      S_SWAP: begin
        hardware_scheduler_en      = 1'b1;
        hardware_scheduler_swap_pc = 1'b1;
        hardware_scheduler_pc      = w_other_pc;
        w_next = S_RUN;
      end
      default: w_next = S_RUN;
    endcase
  end

  assign active_thread = r_active;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_RUN;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_qcnt   <= '0;
      r_dcnt   <= '0;
      r_active <= 1'b0;
      r_valid1 <= 1'b0;
      r_saved0 <= RESET_PC;
      r_saved1 <= RESET_PC;
      r_last   <= RESET_PC;
    end else begin
      if (commit_valid) r_last <= commit_pc_wdata;
      if (thread1_start && !r_valid1) begin
        r_valid1 <= 1'b1;
        r_saved1 <= thread1_start_pc;
      end
      unique case (r_state)
        S_RUN: begin
          if (!dstall && (r_qcnt != QMAX)) r_qcnt <= r_qcnt + QW'(1);
        end
        S_DRAIN: begin
          if (!dstall && (r_dcnt != DMAX)) r_dcnt <= r_dcnt + DW'(1);
        end
        S_SWAP: begin
          if (r_active) r_saved1 <= r_last;
          else          r_saved0 <= r_last;
          r_last   <= w_other_pc;
          r_active <= ~r_active;
          r_qcnt   <= '0;
          r_dcnt   <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hw_thread_scheduler.sv
// Bench for hw_thread_scheduler: directed table, corner sequences and a
// randomized run against a counter-based reference model.
module tb_hw_thread_scheduler;

  localparam int Q = 8;
  localparam int D = 5;
  localparam logic [31:0] RPC = 32'h1eceb000;

  logic        clk = 1'b0;
  logic        rst, commit_valid, dstall, yield_req, thread1_start;
  logic [31:0] commit_pc_wdata, thread1_start_pc;
  logic        en, sw, act;
  logic [31:0] pc;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hw_thread_scheduler #(
    .QUANTUM(Q),
    .DRAIN_CYCLES(D),
    .RESET_PC(RPC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .commit_valid(commit_valid),
    .commit_pc_wdata(commit_pc_wdata),
    .dstall(dstall),
    .yield_req(yield_req),
    .thread1_start(thread1_start),
    .thread1_start_pc(thread1_start_pc),
    .hardware_scheduler_en(en),
    .hardware_scheduler_swap_pc(sw),
    .hardware_scheduler_pc(pc),
    .active_thread(act)
  );

  typedef struct {
    logic        rst;
    logic        cv;
    logic [31:0] wd;
    logic        ds;
    logic        y;
    logic        t1;
    logic [31:0] t1pc;
    logic        en;
    logic        sw;
    logic [31:0] pc;
    logic        act;
  } vec_t;

  vec_t tbl[29];

  task automatic drive(input logic r, input logic cv,
                       input logic [31:0] wd, input logic ds,
                       input logic y, input logic t,
                       input logic [31:0] tpc);
    rst = r;
    commit_valid = cv;
    commit_pc_wdata = wd;
    dstall = ds;
    yield_req = y;
    thread1_start = t;
    thread1_start_pc = tpc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ds);
    drive(1'b0, 1'b0, 32'h0, ds, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic check(input string nm, input logic e_en,
                       input logic e_sw, input logic [31:0] e_pc,
                       input logic e_act);
    n_chk++;
    if (en !== e_en || sw !== e_sw || pc !== e_pc || act !== e_act) begin
      n_fail++;
      $display("FAIL %s t=%0t: got en=%b sw=%b pc=%h act=%b, expected en=%b sw=%b pc=%h act=%b",
               nm, $time, en, sw, pc, act, e_en, e_sw, e_pc, e_act);
    end
  endtask

  task automatic check_int(input string nm, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  // reference model: quantum usage, remaining drain work, pending swap
  int          m_used;
  int          m_drain_left;
  bit          m_swapping;
  bit          m_act;
  bit          m_valid1;
  logic [31:0] m_saved[2];
  logic [31:0] m_last;

  task automatic m_reset();
    m_used = 0;
    m_drain_left = 0;
    m_swapping = 0;
    m_act = 0;
    m_valid1 = 0;
    m_saved[0] = RPC;
    m_saved[1] = RPC;
    m_last = RPC;
  endtask

  task automatic m_step(input logic r, input logic cv,
                        input logic [31:0] wd, input logic ds,
                        input logic y, input logic t,
                        input logic [31:0] tpc);
    bit partner;
    if (r) begin
      m_reset();
      return;
    end
    partner = m_act || m_valid1;
    if (m_swapping) begin
      m_saved[m_act] = m_last;
      m_last = m_saved[!m_act];
      m_act = !m_act;
      m_used = 0;
      m_swapping = 0;
    end else begin
      if (cv) m_last = wd;
      if (m_drain_left > 0) begin
        if (!ds) begin
          m_drain_left--;
          if (m_drain_left == 0) m_swapping = 1;
        end
      end else if (partner && (y || (!ds && m_used == Q - 1))) begin
        m_drain_left = D;
      end else if (!ds && m_used < Q - 1) begin
        m_used++;
      end
    end
    if (t && !m_valid1) begin
      m_valid1 = 1;
      m_saved[1] = tpc;
    end
  endtask

  task automatic m_check(input string nm);
    check(nm, (m_drain_left > 0) || m_swapping, m_swapping,
          m_swapping ? m_saved[!m_act] : 32'h0, m_act);
  endtask

  initial begin
    int cnt_en;
    int cnt_sw;
    int k;
    bit rose;

    foreach (tbl[i]) tbl[i] = '{default: '0};
    tbl[0].rst = 1'b1;
    tbl[2].t1 = 1'b1;
    tbl[2].t1pc = 32'h1ecf0000;
    tbl[10].cv = 1'b1;
    tbl[10].wd = 32'h1eceb040;
    for (int i = 8; i <= 13; i++) tbl[i].en = 1'b1;
    tbl[13].sw = 1'b1;
    tbl[13].pc = 32'h1ecf0000;
    for (int i = 14; i <= 27; i++) tbl[i].act = 1'b1;
    for (int i = 22; i <= 27; i++) tbl[i].en = 1'b1;
    tbl[27].sw = 1'b1;
    tbl[27].pc = 32'h1eceb040;

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].cv, tbl[i].wd, tbl[i].ds,
            tbl[i].y, tbl[i].t1, tbl[i].t1pc);
      check($sformatf("table[%0d]", i), tbl[i].en, tbl[i].sw,
            tbl[i].pc, tbl[i].act);
    end

    // no thread 1: 20 cycles idle, including a dropped yield
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("reset_state", 1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b0, (i == 2 || i == 12), 1'b0, 32'h0);
      check($sformatf("solo[%0d]", i), 1'b0, 1'b0, 32'h0, 1'b0);
    end

    // start in same cycle as saturated expiry: swap follows one cycle later
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h00000100);
    check("start_at_expiry", 1'b0, 1'b0, 32'h0, 1'b0);
    idle(1'b0);
    check("drain_after_start", 1'b1, 1'b0, 32'h0, 1'b0);

    // dstall for 3 cycles mid-drain: 9 en cycles, one swap
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h1ecf0000);
    k = 0;
    while (!en && k < 20) begin
      idle(1'b0);
      k++;
    end
    check_int("drain_entry_timeout", int'(en), 1);
    cnt_en = 1;
    cnt_sw = 0;
    k = 0;
    while (en && k < 20) begin
      idle(k >= 1 && k <= 3);
      if (en) cnt_en++;
      if (sw) cnt_sw++;
      k++;
    end
    check_int("stall_drain_en_cycles", cnt_en, D + 1 + 3);
    check_int("stall_drain_swaps", cnt_sw, 1);
    check("stall_drain_after", 1'b0, 1'b0, 32'h0, 1'b1);

    // yield at qcnt==2 with thread 1 valid
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h1ecf0200);
    idle(1'b0);
    check("pre_yield", 1'b0, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    check("yield_drain", 1'b1, 1'b0, 32'h0, 1'b0);

    // reset in SWAP
    k = 0;
    while (!sw && k < 20) begin
      idle(1'b0);
      k++;
    end
    check("swap_reached", 1'b1, 1'b1, 32'h1ecf0200, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("rst_in_swap", 1'b0, 1'b0, 32'h0, 1'b0);
    rose = 0;
    for (int i = 0; i < 2 * (Q + D); i++) begin
      idle(1'b0);
      if (en || act) rose = 1;
    end
    check_int("thread1_cleared", int'(rose), 0);

    // randomized run against the model
    m_reset();
    for (int c = 0; c < 4000; c++) begin
      logic r, cv, ds, y, t;
      logic [31:0] wd, tpc;
      r   = (c == 0) || ($urandom_range(0, 299) == 0);
      cv  = $urandom_range(0, 1) == 1;
      wd  = $urandom;
      ds  = $urandom_range(0, 3) == 0;
      y   = $urandom_range(0, 15) == 0;
      t   = $urandom_range(0, 19) == 0;
      tpc = $urandom;
      drive(r, cv, wd, ds, y, t, tpc);
      m_step(r, cv, wd, ds, y, t, tpc);
      m_check("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hw_thread_scheduler.md
# hw_thread_scheduler

Two-context hardware thread scheduler for the pipelined core. It time-slices the single fetch/execute pipeline between thread 0 and an optional thread 1. At a quantum expiry or a yield it drains the pipeline using the fetch stage's NOP-insertion port, saves the outgoing thread's resume PC, and redirects fetch to the incoming thread. It drives the `hardware_scheduler_*` inputs of the fetch stage and observes retirement from writeback.

## Interface
Parameters:
- `QUANTUM`, 1024: non-dstall cycles a thread runs before a forced swap (≥2).
- `DRAIN_CYCLES`, 5: non-dstall NOP cycles needed to empty the pipeline (≥1).
- `RESET_PC`, 32'h1eceb000: thread 0 start PC; must equal the PC register's reset value.

Ports:
- `clk` in 1: clock; the block has one clock.
- `rst` in 1: reset, synchronous and active-high.
- `commit_valid` in 1: a real (non-bubble) instruction retires this cycle.
- `commit_pc_wdata` in 32: next-PC of the retiring instruction.
- `dstall` in 1: data-side stall; the pipeline is frozen this cycle.
- `yield_req` in 1: single-cycle pulse; the active thread requests a swap.
- `thread1_start` in 1: pulse; enable thread 1.
- `thread1_start_pc` in 32: thread 1 entry PC, sampled with `thread1_start`.
- `hardware_scheduler_en` out 1: stop fetch, inject NOPs, hold the PC.
- `hardware_scheduler_swap_pc` out 1: load `hardware_scheduler_pc` into the PC register.
- `hardware_scheduler_pc` out 32: PC of the incoming thread.
- `active_thread` out 1: ID of the thread that owns the pipeline.

## Operation
- State per thread: `saved_pc[t]` and `valid[t]`. `valid[0]` is always 1. `valid[1]` is set by `thread1_start` and stays set until reset.
- `last_pc` tracks the active thread's resume point. On each `commit_valid`, `last_pc <= commit_pc_wdata`.
- `thread1_start` takes effect only while `valid[1]==0`. It sets `saved_pc[1] <= thread1_start_pc` and `valid[1] <= 1`. It is ignored when `valid[1]` is already 1.
- FSM states:
  - RUN:
    - Outputs: en=0, swap=0.
    - `qcnt` increments on each cycle where `dstall` is low.
    - `qcnt` saturates at QUANTUM-1 while the other thread is invalid.
    - Go to DRAIN when `valid[~active]` and either (`qcnt==QUANTUM-1` and `dstall` low) or `yield_req`.
    - A `yield_req` while the other thread is invalid is dropped. It is not latched.
  - DRAIN:
    - Outputs: en=1.
    - `dcnt` increments on each cycle where `dstall` is low.
    - Go to SWAP when `dcnt==DRAIN_CYCLES-1` and `dstall` low.
    - Commits continue to update `last_pc`, including mispredict-redirected targets.
  - SWAP (exactly one cycle):
    - Outputs: en=1, swap=1, `hardware_scheduler_pc = saved_pc[~active]`.
    - On exit: `saved_pc[active] <= last_pc`, `last_pc <= saved_pc[~active]`, `active` toggles, `qcnt` and `dcnt` clear, next state is RUN.
- `yield_req` and `thread1_start` arriving in DRAIN or SWAP:
  - `yield_req` is ignored.
  - `thread1_start` is still honoured.
- `hardware_scheduler_pc` is 32'h0 outside SWAP.
- Counter widths are `$clog2` of the parameter.
- The PC register must give `swap_pc` priority over its stall input.

## Timing
- Reset values:
  - state RUN, `active_thread` 0, en 0, swap 0, pc output 0.
  - `qcnt` 0, `dcnt` 0, `valid[1]` 0.
  - `last_pc` RESET_PC; `saved_pc[0]` and `saved_pc[1]` RESET_PC.
- All outputs decode from registered state; there is no combinational path from inputs to outputs.
- Trigger to en: en rises the cycle after the RUN-exit condition is seen.
- Swap overhead is DRAIN_CYCLES + 1 cycles plus one cycle per `dstall` cycle during DRAIN.
- The first fetch of the new thread issues the cycle after SWAP.
- If quantum expiry and `thread1_start` fall in the same cycle, there is no swap that cycle. The swap starts on the next non-dstall cycle because `qcnt` is saturated.
- If `yield_req` and quantum expiry coincide, there is a single transition to DRAIN.
- `rst` mid-DRAIN or mid-SWAP returns to RUN on thread 0 with en=0 on the next edge; all context is lost.
- A swap with no commits in the quantum saves back the same PC that was loaded, so the outgoing thread resumes where it started.

## Test plan
All scenarios use QUANTUM=8 and DRAIN_CYCLES=5.
- Reset, no thread 1, 20 cycles -> en=0 throughout, `active_thread` 0, `hardware_scheduler_pc` 0.
- `thread1_start` with PC 0x1ecf0000 at cycle 2, no stalls -> en high for 6 cycles. swap=1 with pc 0x1ecf0000 on the 6th of those cycles; `active_thread` becomes 1 the next cycle.
- Commit with pc_wdata 0x1eceb040 during DRAIN, then swap back after thread 1's quantum -> `hardware_scheduler_pc` is 0x1eceb040.
- `dstall` held for 3 cycles mid-DRAIN -> en high for 9 cycles; swap pulses exactly once.
- `yield_req` at `qcnt`=2 with thread 1 valid -> DRAIN on the next cycle. The same `yield_req` with thread 1 invalid -> no effect.
- `rst` during SWAP -> next cycle en=0, swap=0, `active_thread` 0, `valid[1]` 0.
